// File: rtl/sim_mem_pkg.sv
// Shared default widths and the response-queue entry layout for sim_mem_responder.
package sim_mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 64;
    localparam int unsigned DEF_LOGSIZE_WIDTH = 8;
    localparam int unsigned DEF_LATENCY       = 4;

    // The countdown only ever holds LATENCY-1, but it keeps at least one bit so it stays a legal field.
    function automatic int unsigned cd_width(input int unsigned latency);
        return (latency <= 2) ? 1 : $clog2(latency);
    endfunction

    typedef struct packed {
        logic                               is_store;
        logic [DEF_LOGSIZE_WIDTH-1:0]       size;
        logic [cd_width(DEF_LATENCY)-1:0]   countdown;
    } resp_entry_t;

endpackage

// File: rtl/sim_mem_lane_queue.sv
// One lane of the responder: an in-order FIFO of pending acknowledgements.
// Every stored entry counts down in parallel, so a stalled head does not delay the entries behind it.
module sim_mem_lane_queue
    import sim_mem_pkg::*;
#(
    parameter int unsigned LOGSIZE_WIDTH = DEF_LOGSIZE_WIDTH,
    parameter int unsigned LATENCY       = DEF_LATENCY,
    parameter int unsigned DEPTH         = 4,
    parameter type         entry_t       = resp_entry_t
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_a_valid,
    input  logic                     i_a_is_store,
    input  logic [LOGSIZE_WIDTH-1:0] i_a_size,
    output logic                     o_a_ready,
    input  logic                     i_d_ready,
    output logic                     o_d_valid,
    output logic                     o_d_is_store,
    output logic [LOGSIZE_WIDTH-1:0] o_d_size,
    output logic                     o_nonempty
);

    localparam int unsigned       PTR_W   = $clog2(DEPTH);
    localparam int unsigned       CNT_W   = PTR_W + 1;
    localparam int unsigned       CD_W    = cd_width(LATENCY);
    localparam logic [CD_W-1:0]   CD_LOAD = CD_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);

    entry_t             r_mem      [DEPTH];
    entry_t             w_mem_next [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    entry_t w_head;
    entry_t w_new;
    logic   w_push;
    logic   w_pop;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_new        = '{is_store: i_a_is_store, size: i_a_size, countdown: CD_LOAD};

    // Ready comes only from the registered count, so a full lane popping this cycle still refuses.
    assign o_nonempty   = (r_count != '0);
    assign o_a_ready    = (r_count != FULL);
    assign o_d_valid    = o_nonempty && (w_head.countdown == '0);
    assign o_d_is_store = o_nonempty & w_head.is_store;
    assign o_d_size     = o_nonempty ? w_head.size : '0;

    assign w_push       = i_a_valid & o_a_ready;
    assign w_pop        = o_d_valid & i_d_ready;

    // The push slot is never occupied (push needs count < DEPTH), so loading it over its aging is safe.
    always_comb begin
        w_mem_next = r_mem;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_mem[i].countdown != '0) begin
                w_mem_next[i].countdown = r_mem[i].countdown - CD_W'(1);
            end
        end
        if (w_push) begin
            w_mem_next[r_wr_ptr] = w_new;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_mem <= w_mem_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sim_mem_responder.sv
// Multi-lane fixed-latency memory responder: acknowledges each A request on D, in per-lane order.
// Holds no backing store; address and store data are consumed and dropped.
module sim_mem_responder
    import sim_mem_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned LOGSIZE_WIDTH = DEF_LOGSIZE_WIDTH,
    parameter int unsigned LATENCY       = DEF_LATENCY,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    output logic [NUM_LANES-1:0]               a_ready,
    input  logic [NUM_LANES-1:0]               a_valid,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_address,
    input  logic [NUM_LANES-1:0]               a_is_store,
    input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size,
    input  logic [DATA_WIDTH*NUM_LANES-1:0]    a_data,
    input  logic [NUM_LANES-1:0]               d_ready,
    output logic [NUM_LANES-1:0]               d_valid,
    output logic [NUM_LANES-1:0]               d_is_store,
    output logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size,
    output logic                               inflight,
    output logic [31:0]                        resp_count
);

    // Same layout as resp_entry_t, sized for this instance's parameters.
    typedef struct packed {
        logic                               is_store;
        logic [LOGSIZE_WIDTH-1:0]           size;
        logic [cd_width(LATENCY)-1:0]       countdown;
    } lane_entry_t;

    logic [NUM_LANES-1:0] w_nonempty;
    logic [NUM_LANES-1:0] w_pop;
    logic [31:0]          r_resp_count;
    logic                 w_unused_sink;

    assign w_unused_sink = ^{a_address, a_data};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        sim_mem_lane_queue #(
            .LOGSIZE_WIDTH (LOGSIZE_WIDTH),
            .LATENCY       (LATENCY),
            .DEPTH         (DEPTH),
            .entry_t       (lane_entry_t)
        ) u_queue (
            .i_clk        (clock),
            .i_rst_n      (reset),
            .i_a_valid    (a_valid[g]),
            .i_a_is_store (a_is_store[g]),
            .i_a_size     (a_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH]),
            .o_a_ready    (a_ready[g]),
            .i_d_ready    (d_ready[g]),
            .o_d_valid    (d_valid[g]),
            .o_d_is_store (d_is_store[g]),
            .o_d_size     (d_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH]),
            .o_nonempty   (w_nonempty[g])
        );
    end

    assign w_pop      = d_valid & d_ready;
    assign inflight   = |w_nonempty;
    assign resp_count = r_resp_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_resp_count <= '0;
        end else begin
            r_resp_count <= r_resp_count + 32'($countones(w_pop));
        end
    end

endmodule

// File: tb/tb_sim_mem_responder.sv
// Self-checking bench for sim_mem_responder: vector table, directed corner sequences and
// random traffic, all compared against a timestamp-queue model of the responder.
`timescale 1ns/1ps
module tb_sim_mem_responder;

    localparam int NL  = 4;
    localparam int DW  = 64;
    localparam int LW  = 8;
    localparam int LAT = 4;
    localparam int DEP = 4;
    localparam int MB  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [NL-1:0]     a_ready;
    logic [NL-1:0]     a_valid;
    logic [DW*NL-1:0]  a_address;
    logic [NL-1:0]     a_is_store;
    logic [LW*NL-1:0]  a_size;
    logic [DW*NL-1:0]  a_data;
    logic [NL-1:0]     d_ready;
    logic [NL-1:0]     d_valid;
    logic [NL-1:0]     d_is_store;
    logic [LW*NL-1:0]  d_size;
    logic              inflight;
    logic [31:0]       resp_count;

    sim_mem_responder #(
        .NUM_LANES     (NL),
        .DATA_WIDTH    (DW),
        .LOGSIZE_WIDTH (LW),
        .LATENCY       (LAT),
        .DEPTH         (DEP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .a_ready    (a_ready),
        .a_valid    (a_valid),
        .a_address  (a_address),
        .a_is_store (a_is_store),
        .a_size     (a_size),
        .a_data     (a_data),
        .d_ready    (d_ready),
        .d_valid    (d_valid),
        .d_is_store (d_is_store),
        .d_size     (d_size),
        .inflight   (inflight),
        .resp_count (resp_count)
    );

    logic clk_run = 1'b0;
    initial begin
        wait (clk_run);
        forever #5 clock = ~clock;
    end

    // Reference model: each accepted request becomes a queue entry stamped with the
    // edge index after which it may be answered (accept edge + LAT - 1).
    typedef struct {
        logic          st;
        logic [LW-1:0] sz;
        int            due;
    } ment_t;

    ment_t       mbuf [NL][MB];
    int          mhead [NL];
    int          mtail [NL];
    int          cyc = 0;
    logic [31:0] m_resp = '0;
    int          total = 0;
    int          bad = 0;

    function automatic int mcount(input int g);
        return mtail[g] - mhead[g];
    endfunction

    function automatic logic m_dvalid(input int g, input int at);
        return (mcount(g) > 0) && (at >= mbuf[g][mhead[g] % MB].due);
    endfunction

    task automatic model_clear();
        for (int g = 0; g < NL; g++) begin
            mhead[g] = 0;
            mtail[g] = 0;
        end
        m_resp = '0;
    endtask

    task automatic model_edge();
        cyc++;
        if (!reset) begin
            model_clear();
            return;
        end
        for (int g = 0; g < NL; g++) begin
            logic pop;
            logic push;
            pop  = m_dvalid(g, cyc - 1) && d_ready[g];
            push = a_valid[g] && (mcount(g) < DEP);
            if (pop) begin
                mhead[g]++;
                m_resp++;
            end
            if (push) begin
                mbuf[g][mtail[g] % MB].st  = a_is_store[g];
                mbuf[g][mtail[g] % MB].sz  = a_size[LW*g +: LW];
                mbuf[g][mtail[g] % MB].due = cyc + LAT - 1;
                mtail[g]++;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic check_model();
        logic [NL-1:0]    e_ar;
        logic [NL-1:0]    e_dv;
        logic [NL-1:0]    e_st;
        logic [LW*NL-1:0] e_sz;
        for (int g = 0; g < NL; g++) begin
            e_ar[g] = mcount(g) < DEP;
            e_dv[g] = m_dvalid(g, cyc);
            e_st[g] = 1'b0;
            e_sz[LW*g +: LW] = '0;
            if (mcount(g) > 0) begin
                e_st[g] = mbuf[g][mhead[g] % MB].st;
                e_sz[LW*g +: LW] = mbuf[g][mhead[g] % MB].sz;
            end
        end
        chk("model_a_ready",    64'(a_ready),    64'(e_ar));
        chk("model_d_valid",    64'(d_valid),    64'(e_dv));
        chk("model_d_is_store", 64'(d_is_store), 64'(e_st));
        chk("model_d_size",     64'(d_size),     64'(e_sz));
        chk("model_inflight",   64'(inflight),   64'(|{e_ar == '1 ? 1'b0 : 1'b1, mcount(0) > 0, mcount(1) > 0, mcount(2) > 0, mcount(3) > 0}));
        chk("model_resp_count", 64'(resp_count), 64'(m_resp));
    endtask

    task automatic step(input logic [NL-1:0] av, input logic [NL-1:0] st,
                        input logic [LW*NL-1:0] sz, input logic [NL-1:0] dr);
        a_valid    = av;
        a_is_store = st;
        a_size     = sz;
        d_ready    = dr;
        for (int i = 0; i < DW*NL/32; i++) begin
            a_address[32*i +: 32] = $urandom;
            a_data[32*i +: 32]    = $urandom;
        end
        @(posedge clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        step('0, '0, '0, '0);
        step('0, '0, '0, '0);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [NL-1:0]    av;
        logic [NL-1:0]    st;
        logic [LW*NL-1:0] sz;
        logic [NL-1:0]    dr;
        logic [NL-1:0]    dv;
        logic [NL-1:0]    ar;
        logic             inf;
        logic [31:0]      rc;
    } vec_t;

    vec_t vt [11];
    int   acc [NL];
    logic [NL-1:0] ar_pre;
    logic [NL-1:0] av_s;
    logic          done;

    initial begin
        // Lane 0: one load of size 3, then lane 1: two back-to-back requests, d_ready held high.
        vt[0]  = '{4'b0001, 4'b0000, 32'h0000_0003, 4'b1111, 4'b0000, 4'b1111, 1'b1, 32'd0};
        vt[1]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b1111, 4'b0000, 4'b1111, 1'b1, 32'd0};
        vt[2]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b1111, 4'b0000, 4'b1111, 1'b1, 32'd0};
        vt[3]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b1111, 4'b0001, 4'b1111, 1'b1, 32'd0};
        vt[4]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b1111, 4'b0000, 4'b1111, 1'b0, 32'd1};
        vt[5]  = '{4'b0010, 4'b0010, 32'h0000_0500, 4'b1111, 4'b0000, 4'b1111, 1'b1, 32'd1};
        vt[6]  = '{4'b0010, 4'b0000, 32'h0000_0600, 4'b1111, 4'b0000, 4'b1111, 1'b1, 32'd1};
        vt[7]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b1111, 4'b0000, 4'b1111, 1'b1, 32'd1};
        vt[8]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b1111, 4'b0010, 4'b1111, 1'b1, 32'd1};
        vt[9]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b1111, 4'b0010, 4'b1111, 1'b1, 32'd2};
        vt[10] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b1111, 4'b0000, 4'b1111, 1'b0, 32'd3};

        // Reset values with no clock running.
        reset = 1'b0;
        a_valid = '0; a_is_store = '0; a_size = '0; d_ready = '0;
        a_address = '0; a_data = '0;
        model_clear();
        #2;
        chk("rst_a_ready",    64'(a_ready),    64'(4'b1111));
        chk("rst_d_valid",    64'(d_valid),    64'(4'b0000));
        chk("rst_d_size",     64'(d_size),     64'(32'd0));
        chk("rst_inflight",   64'(inflight),   64'(1'b0));
        chk("rst_resp_count", 64'(resp_count), 64'(32'd0));
        clk_run = 1'b1;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            step(vt[i].av, vt[i].st, vt[i].sz, vt[i].dr);
            chk($sformatf("vec%0d_d_valid", i),    64'(d_valid),    64'(vt[i].dv));
            chk($sformatf("vec%0d_a_ready", i),    64'(a_ready),    64'(vt[i].ar));
            chk($sformatf("vec%0d_inflight", i),   64'(inflight),   64'(vt[i].inf));
            chk($sformatf("vec%0d_resp_count", i), 64'(resp_count), 64'(vt[i].rc));
        end

        // Lane 2 fills under backpressure, then drains in order on consecutive cycles.
        for (int k = 0; k < 4; k++) step(4'b0100, '0, 32'(k + 1) << 16, 4'b0000);
        chk("full_a_ready2", 64'(a_ready[2]), 64'(1'b0));
        for (int k = 0; k < 10; k++) step('0, '0, '0, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_d_valid2", k), 64'(d_valid[2]),    64'(1'b1));
            chk($sformatf("drain%0d_d_size2", k),  64'(d_size[23:16]), 64'(k + 1));
            step((k == 0) ? 4'b0100 : 4'b0000, '0, 32'h00EE_0000, 4'b1111);
            if (k == 0) chk("pop_full_a_ready2", 64'(a_ready[2]), 64'(1'b1));
        end
        chk("drained_d_valid2", 64'(d_valid[2]), 64'(1'b0));

        // Lane 1 holding two entries: push and pop on the same edge.
        step(4'b0010, '0, 32'h0000_0700, 4'b0000);
        step(4'b0010, '0, 32'h0000_0800, 4'b0000);
        for (int k = 0; k < 4; k++) step('0, '0, '0, 4'b0000);
        step(4'b0010, '0, 32'h0000_0900, 4'b0010);
        chk("pp_d_valid1", 64'(d_valid[1]),   64'(1'b1));
        chk("pp_d_size1",  64'(d_size[15:8]), 64'(8'h08));
        step('0, '0, '0, 4'b0010);
        chk("pp_next_d_valid1", 64'(d_valid[1]),   64'(1'b0));
        chk("pp_next_d_size1",  64'(d_size[15:8]), 64'(8'h09));
        for (int k = 0; k < 4; k++) step('0, '0, '0, 4'b1111);
        chk("pp_inflight", 64'(inflight), 64'(1'b0));

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom), 4'($urandom), $urandom, 4'($urandom | $urandom));
        end
        for (int k = 0; k < 12; k++) step('0, '0, '0, 4'b1111);

        // All lanes streaming until 100 requests per lane are accepted.
        do_reset();
        for (int g = 0; g < NL; g++) acc[g] = 0;
        done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            for (int g = 0; g < NL; g++) av_s[g] = acc[g] < 100;
            ar_pre = a_ready;
            step(av_s, 4'($urandom), $urandom, 4'b1111);
            done = 1'b1;
            for (int g = 0; g < NL; g++) begin
                if (av_s[g] && ar_pre[g]) acc[g]++;
                if (acc[g] < 100) done = 1'b0;
            end
        end
        chk("stream_all_accepted", 64'(done), 64'(1'b1));
        for (int k = 0; k < 10; k++) step('0, '0, '0, 4'b1111);
        chk("stream_resp_count", 64'(resp_count), 64'(32'd400));
        chk("stream_inflight",   64'(inflight),   64'(1'b0));

        // Reset mid-flight with three responses pending on lane 3.
        for (int k = 0; k < 3; k++) step(4'b1000, 4'($urandom), $urandom, 4'b0000);
        for (int k = 0; k < 4; k++) step('0, '0, '0, 4'b0000);
        chk("pre_rst_d_valid3", 64'(d_valid[3]), 64'(1'b1));
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        chk("midrst_d_valid",    64'(d_valid),    64'(4'b0000));
        chk("midrst_inflight",   64'(inflight),   64'(1'b0));
        chk("midrst_a_ready",    64'(a_ready),    64'(4'b1111));
        chk("midrst_resp_count", 64'(resp_count), 64'(32'd0));
        step('0, '0, '0, 4'b1111);
        step('0, '0, '0, 4'b1111);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) step('0, '0, '0, 4'b1111);
        chk("post_rst_resp_count", 64'(resp_count), 64'(32'd0));
        chk("post_rst_d_valid",    64'(d_valid),    64'(4'b0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
